// File: rtl/matrix_3x3_pkg.sv
// Shared types and constants for the 3x3 window generator.
// The optional FIFO underflow monitor is enabled by defining MATRIX_UNDERFLOW_CHK_EN.
package matrix_3x3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int FLUSH_CYCLES    = 4;
  // lb_clr covers the last two flush cycles, after the pipeline has drained
  localparam int FLUSH_CLR_START = 2;

  localparam int P11 = 0;
  localparam int P12 = 1;
  localparam int P13 = 2;
  localparam int P21 = 3;
  localparam int P22 = 4;
  localparam int P23 = 5;
  localparam int P31 = 6;
  localparam int P32 = 7;
  localparam int P33 = 8;

  // Row-major tap position; row 0 is the oldest line, col 0 the oldest column
  function automatic int tap_idx(input int row, input int col);
    return row * 3 + col;
  endfunction

endpackage

// File: rtl/matrix_3x3_shift.sv
// 3-row x 3-column tap register; each shift pushes a new column in on the right.
// The tap registers drive o_win_data directly, p11 in the LSBs and p33 in the MSBs.
module matrix_3x3_shift
  import matrix_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_shift_en,
  input  logic [DATA_WIDTH-1:0]   i_col_top,
  input  logic [DATA_WIDTH-1:0]   i_col_mid,
  input  logic [DATA_WIDTH-1:0]   i_col_bot,
  output logic [9*DATA_WIDTH-1:0] o_win_data
);

  logic [DATA_WIDTH-1:0] w_col_in [0:2];

  assign w_col_in[0] = i_col_top;
  assign w_col_in[1] = i_col_mid;
  assign w_col_in[2] = i_col_bot;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [DATA_WIDTH-1:0] r_tap [0:2];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_tap[0] <= '0;
          r_tap[1] <= '0;
          r_tap[2] <= '0;
        end else if (i_shift_en) begin
          r_tap[0] <= r_tap[1];
          r_tap[1] <= r_tap[2];
          r_tap[2] <= w_col_in[gi];
        end
      end

      for (gj = 0; gj < 3; gj++) begin : g_col
        assign o_win_data[tap_idx(gi, gj)*DATA_WIDTH +: DATA_WIDTH] = r_tap[gj];
      end
    end
  endgenerate

endmodule

// File: rtl/matrix_3x3_window.sv
// Streaming 3x3 neighbourhood generator cascading rows through two external line FIFOs.
// Define MATRIX_UNDERFLOW_CHK_EN to add the rd_empty inputs and the sticky underflow flag.
module matrix_3x3_window
  import matrix_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_valid,
  input  logic                    pix_sof,
  input  logic [DATA_WIDTH-1:0]   pix_data,
  output logic                    pix_ready,
  output logic                    lb0_wr_en,
  output logic [DATA_WIDTH-1:0]   lb0_wr_data,
  output logic                    lb0_rd_en,
  input  logic [DATA_WIDTH-1:0]   lb0_rd_data,
  output logic                    lb1_wr_en,
  output logic [DATA_WIDTH-1:0]   lb1_wr_data,
  output logic                    lb1_rd_en,
  input  logic [DATA_WIDTH-1:0]   lb1_rd_data,
`ifdef MATRIX_UNDERFLOW_CHK_EN
  input  logic                    lb0_rd_empty,
  input  logic                    lb1_rd_empty,
`endif
  output logic                    lb_clr,
  output logic                    win_valid,
  output logic [9*DATA_WIDTH-1:0] win_data,
  output logic                    sync_err,
  output logic                    underflow_err
);

  localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int FCNT_W = $clog2(FLUSH_CYCLES);

  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0]  ROW_PENULT = ROW_W'(IMG_HEIGHT - 2);
  localparam logic [FCNT_W-1:0] FCNT_LAST  = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FCNT_CLR   = FCNT_W'(FLUSH_CLR_START);

  state_t              r_state;
  state_t              w_state_next;
  logic [FCNT_W-1:0]   r_flush_cnt;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;

  logic                w_accept;
  logic                w_take;
  logic                w_sof_err;
  logic                w_last;
  logic                w_kill;
  logic                w_shift;
  logic                w_row_ge1;
  logic                w_row_ge2;
  logic                w_row_le_penult;
  logic                w_col_ge2;

  logic                  r_lb0_wr_en;
  logic                  r_lb0_rd_en;
  logic                  r_lb1_rd_en;
  logic                  r_lb1_wr_en;
  logic [DATA_WIDTH-1:0] r_lb1_wr_data;
  logic                  r_win_valid;
  logic                  r_sync_err;

  logic                  r_s1_valid;
  logic                  r_s1_lb1_wr;
  logic                  r_s1_win;
  logic [DATA_WIDTH-1:0] r_s1_pix;
  logic                  r_s2_valid;
  logic                  r_s2_lb1_wr;
  logic                  r_s2_win;
  logic [DATA_WIDTH-1:0] r_s2_pix;

  // Handshake decode: IDLE only takes a frame start, RUN treats any sof as a sync loss
  assign w_accept  = pix_valid && pix_ready;
  assign w_take    = w_accept && (((r_state == IDLE) && pix_sof) ||
                                  ((r_state == RUN) && !pix_sof));
  assign w_sof_err = w_accept && (r_state == RUN) && pix_sof;
  assign w_last    = (r_col == COL_LAST) && (r_row == ROW_LAST);

  assign w_row_ge1       = (r_row != '0);
  assign w_row_ge2       = (r_row > ROW_W'(1));
  assign w_row_le_penult = (r_row <= ROW_PENULT);
  assign w_col_ge2       = (r_col > COL_W'(1));

  // In-flight pixels of an aborted frame are discarded so no writes reach the FIFOs while flushing
  assign w_kill  = w_sof_err || (r_state == FLUSH);
  assign w_shift = r_s2_valid && !w_kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      if ((r_state == RUN) || (r_state == FLUSH)) begin
        r_state <= FLUSH;
      end else begin
        r_state <= IDLE;
      end
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_sof_err) begin
          w_state_next = FLUSH;
        end else if (w_take && w_last) begin
          w_state_next = IDLE;
        end
      end
      FLUSH: begin
        if (r_flush_cnt == FCNT_LAST) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    pix_ready = 1'b0;
    lb_clr    = 1'b0;
    if (!rst) begin
      pix_ready = (r_state != FLUSH);
      lb_clr    = (r_state == FLUSH) && (r_flush_cnt >= FCNT_CLR);
    end
  end

  // Held at zero through rst so a mid-frame reset replays the full flush afterwards
  always_ff @(posedge clk) begin
    if (rst || (r_state != FLUSH)) begin
      r_flush_cnt <= '0;
    end else begin
      r_flush_cnt <= r_flush_cnt + FCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state == FLUSH)) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_take) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lb0_wr_en   <= 1'b0;
      r_lb0_rd_en   <= 1'b0;
      r_lb1_rd_en   <= 1'b0;
      r_s1_valid    <= 1'b0;
      r_s1_lb1_wr   <= 1'b0;
      r_s1_win      <= 1'b0;
      r_s1_pix      <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_lb1_wr   <= 1'b0;
      r_s2_win      <= 1'b0;
      r_s2_pix      <= '0;
      r_lb1_wr_en   <= 1'b0;
      r_lb1_wr_data <= '0;
      r_win_valid   <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_lb0_wr_en <= w_take && w_row_le_penult;
      r_lb0_rd_en <= w_take && w_row_ge1;
      r_lb1_rd_en <= w_take && w_row_ge2;
      r_s1_valid  <= w_take;
      r_s1_lb1_wr <= w_row_ge1 && w_row_le_penult;
      r_s1_win    <= w_row_ge2 && w_col_ge2;
      if (w_take) begin
        r_s1_pix <= pix_data;
      end

      // FIFO read data lands alongside stage 2
      r_s2_valid  <= r_s1_valid && !w_kill;
      r_s2_lb1_wr <= r_s1_lb1_wr;
      r_s2_win    <= r_s1_win;
      r_s2_pix    <= r_s1_pix;

      r_lb1_wr_en <= w_shift && r_s2_lb1_wr;
      if (w_shift && r_s2_lb1_wr) begin
        r_lb1_wr_data <= lb0_rd_data;
      end
      r_win_valid <= w_shift && r_s2_win;
      r_sync_err  <= w_sof_err;
    end
  end

  matrix_3x3_shift #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .i_shift_en (w_shift),
    .i_col_top  (lb1_rd_data),
    .i_col_mid  (lb0_rd_data),
    .i_col_bot  (r_s2_pix),
    .o_win_data (win_data)
  );

`ifdef MATRIX_UNDERFLOW_CHK_EN
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_underflow <= 1'b0;
    end else if ((r_lb0_rd_en && lb0_rd_empty) || (r_lb1_rd_en && lb1_rd_empty)) begin
      r_underflow <= 1'b1;
    end
  end

  assign underflow_err = r_underflow;
`else
  assign underflow_err = 1'b0;
`endif

  assign lb0_wr_en   = r_lb0_wr_en;
  assign lb0_wr_data = r_s1_pix;
  assign lb0_rd_en   = r_lb0_rd_en;
  assign lb1_wr_en   = r_lb1_wr_en;
  assign lb1_wr_data = r_lb1_wr_data;
  assign lb1_rd_en   = r_lb1_rd_en;
  assign win_valid   = r_win_valid;
  assign sync_err    = r_sync_err;

endmodule

// File: doc/matrix_3x3_window.md
# matrix_3x3_window

Streaming 3x3 neighbourhood generator for the 3x3 matrix demo. It sits directly upstream of, and drives, two external `fifo_line_buffer` instances (8-bit, 4096 deep, read data one cycle after `rd_en`, no output register). It accepts a raster pixel stream and cascades rows through the two FIFOs. It emits one registered 3x3 window per interior pixel to the downstream filter stage.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width; must equal the FIFO data width.
- IMG_WIDTH, 640, pixels per line; legal range 3..4096 (FIFO depth).
- IMG_HEIGHT, 480, lines per frame; minimum 3.

Ports (clock and reset first):
- clk  in  1  single clock for the block and both FIFOs.
- rst  in  1  synchronous, active-high reset.
- pix_valid  in  1  input pixel valid.
- pix_sof  in  1  marks the first pixel of a frame; qualified by pix_valid.
- pix_data  in  DATA_WIDTH  input pixel.
- pix_ready  out  1  block accepts the pixel when pix_valid and pix_ready are both high.
- lb0_wr_en / lb0_wr_data  out  1 / DATA_WIDTH  write port of FIFO0 (holds the previous row).
- lb0_rd_en  out  1  read enable for FIFO0.
- lb0_rd_data  in  DATA_WIDTH  read data from FIFO0.
- lb1_wr_en / lb1_wr_data / lb1_rd_en  out  write and read controls for FIFO1 (holds the row two above).
- lb1_rd_data  in  DATA_WIDTH  read data from FIFO1.
- lb_clr  out  1  drives the wr_rst and rd_rst inputs of both FIFOs.
- win_valid  out  1  window valid.
- win_data  out  9*DATA_WIDTH  window taps, row-major; p11 (top-left) in the LSBs, p33 (newest) in the MSBs.
- sync_err  out  1  one-cycle pulse on an unexpected pix_sof.
- underflow_err  out  1  sticky flag; see Configuration.

## Operation
- Counters:
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1.
  - Widths are $clog2 of the respective dimension.
  - Both advance on each accepted pixel; col wraps to 0 and increments row.
- FSM states:
  - IDLE: pix_ready=1. Pixels without pix_sof are dropped. A pixel with pix_sof becomes position (0,0) and the FSM moves to RUN.
  - RUN: pix_ready=1. Accepting pixel (H-1, W-1) moves the FSM to IDLE. pix_sof on any pixel other than the expected (0,0) position: pulse sync_err, drop that pixel, move to FLUSH.
  - FLUSH: pix_ready=0 for 4 cycles. Cycles 1-2 drain the pipeline with no writes issued. Cycles 3-4 hold lb_clr=1. Counters clear, then the FSM moves to IDLE.
- Line buffer traffic for a pixel accepted at row r:
  - FIFO0 is written when r ≤ H-2 and read when r ≥ 1.
  - FIFO1 is written with the FIFO0 read data when 1 ≤ r ≤ H-2, and read when r ≥ 2.
  - Both FIFOs are therefore empty at frame end.
- Window:
  - Column taps are {lb1_rd_data, lb0_rd_data, pixel}. These shift into a 3-column register.
  - win_valid=1 iff the source pixel has r ≥ 2 and c ≥ 2. The window centre is (r-1, c-1).
  - Produces (H-2)*(W-2) windows per frame. No border padding.
- A FIFO full condition cannot occur under the legal parameter range, so it is not monitored.

## Timing
- Pixel accepted in cycle t:
  - t+1: registered lb0_wr_en and lb0_rd_en/lb1_rd_en asserted as applicable.
  - t+2: lb0_rd_data and lb1_rd_data are valid.
  - t+3: lb1_wr_en carries the registered lb0_rd_data, and win_valid/win_data are registered.
- Latency is 3 cycles. Throughput is one pixel per cycle. Gaps in pix_valid stall the pipeline without corrupting it.
- Reset values:
  - pix_ready=0 during rst, then 1 in IDLE.
  - All other outputs 0: win_valid, win_data, lb*_wr_en, lb*_rd_en, lb*_wr_data, lb_clr, sync_err, underflow_err.
  - FSM returns to IDLE and counters clear.
- rst mid-frame: the FSM passes through the FLUSH lb_clr sequence before IDLE, so the FIFOs are cleared.
- pix_sof arriving on the final pixel position of a frame is a sync error (FLUSH).

## Configuration
- Macro `MATRIX_UNDERFLOW_CHK_EN`.
- Defined: underflow_err is set when lb0_rd_en or lb1_rd_en is asserted while that FIFO's rd_empty is high. This adds inputs lb0_rd_empty and lb1_rd_empty. The flag clears only on rst.
- Undefined: the rd_empty inputs are absent and underflow_err is tied to 0.

## Structure
- Package matrix_3x3_pkg holds:
  - the FSM state enum (IDLE, RUN, FLUSH);
  - FLUSH_CYCLES=4;
  - tap index constants P11..P33.
- Sub-module matrix_3x3_shift: the 3-column x 3-row tap register with shift enable and a registered win_data output.

## Test plan
Bench uses DATA_WIDTH=8, IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = r*16+c, and FIFO models with 1-cycle read latency.
- One frame, sof on the first pixel -> exactly 4 win_valid pulses. The first arrives 3 cycles after pixel (2,2), with p11=0x00, p22=0x11, p33=0x22.
- Same frame with pix_valid toggling every other cycle -> identical win_data sequence; both FIFOs empty at frame end.
- pix_sof on pixel (1,2) -> sync_err pulses once, pix_ready low for 4 cycles, lb_clr high in cycles 3-4. The next sof frame produces correct windows.
- Pixels before the first sof -> dropped; no FIFO writes and no win_valid.
- rst asserted mid-frame -> all outputs 0, FIFOs cleared, the next frame is correct.
- With `MATRIX_UNDERFLOW_CHK_EN`, the FIFO0 model forces rd_empty=1 during a read -> underflow_err rises and stays high until rst.
